// File: rtl/dlx_imem_ctrl.sv
// dlx_imem_ctrl: instruction-memory controller for the DLX core.
// It first takes a program over a streaming load port and writes it into
// its RAM. It then serves instruction fetches from the core. The core is
// held in reset until a program has been loaded. A fetch past the end of
// the program returns NOP_WORD.
//
// Optional feature (compile-time macro IMEM_PARITY_EN):
//   When defined, each RAM word carries an even-parity bit in bit 32.
//   Every fetch hit is checked against that bit. On a mismatch the fetch
//   returns NOP_WORD and the sticky ParErr flag is set.
//   When not defined, the RAM is 32 bits wide and ParErr is tied to 0.
//
// Load handshake: a word moves from the source into the RAM on a rising
// edge of PHI1 where LdValid and LdReady are both 1. The source holds
// LdData/LdLast stable while LdValid=1 and LdReady=0. LdReady does not
// depend on LdValid. A word offered in the same cycle as LdStart is dropped.
module dlx_imem_ctrl #(
    parameter int          MEMSIZE  = 26,
    parameter int          AW       = 5,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          PHI1,
    input  logic          MRST,
    input  logic          LdStart,
    input  logic          LdValid,
    input  logic [31:0]   LdData,
    input  logic          LdLast,
    output logic          LdReady,
    input  logic          IRead,
    input  logic [31:0]   IAddr,
    output logic [31:0]   IIn,
    output logic          IValid,
    output logic          CpuRst,
    output logic [AW:0]   ProgLen,
    output logic          AddrErr,
    output logic          ParErr,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

`ifdef IMEM_PARITY_EN
    localparam int RW = 33;
`else
    localparam int RW = 32;
`endif

    localparam logic [AW:0] MEMSIZE_W = (AW + 1)'(MEMSIZE);
    localparam logic [AW:0] ONE_W     = (AW + 1)'(1);

    state_t          r_state;
    state_t          w_next;
    logic [RW-1:0]   r_mem [0:MEMSIZE-1];
    // The load write pointer and the program length always hold the same
    // value, so one register serves as both.
    logic [AW:0]     r_prog_len;
    logic [31:0]     r_iin;
    logic            r_ivalid;
    logic            r_cpu_rst;
    logic            r_addr_err;
    logic            r_par_err;

    logic            w_ld_ready;
    logic            w_accept;
    logic            w_fetch;
    logic [AW-1:0]   w_idx;
    logic            w_aligned;
    logic            w_in_range;
    logic [RW-1:0]   w_rd_word;
    logic            w_par_bad;
    logic            w_hit;

    // Load-side handshake and fetch qualification
    always_comb begin
        w_ld_ready = (r_state == S_LOAD) && (r_prog_len < MEMSIZE_W);
        w_accept   = w_ld_ready && LdValid && !LdStart;
        w_fetch    = (r_state == S_RUN) && !r_cpu_rst && IRead && !LdStart;
        w_idx      = IAddr[AW+1:2];
        w_aligned  = (IAddr[1:0] == 2'b00);
        w_in_range = (IAddr[31:AW+2] == '0) && ({1'b0, w_idx} < r_prog_len);
        w_rd_word  = r_mem[w_idx];
`ifdef IMEM_PARITY_EN
        w_par_bad  = ^w_rd_word;
`else
        w_par_bad  = 1'b0;
`endif
        w_hit      = w_aligned && w_in_range && !w_par_bad;
    end

    // State register
    always_ff @(posedge PHI1) begin
        if (MRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; LdStart restarts a load from any state
    always_comb begin
        w_next = r_state;
        if (LdStart) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_LOAD: begin
                    if (w_accept && (LdLast || ((r_prog_len + ONE_W) == MEMSIZE_W))) begin
                        w_next = S_RUN;
                    end
                end
                S_RUN:   w_next = S_RUN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Program RAM write port; contents survive reset
    always_ff @(posedge PHI1) begin
        if (!MRST && w_accept) begin
`ifdef IMEM_PARITY_EN
            r_mem[r_prog_len[AW-1:0]] <= {^LdData, LdData};
`else
            r_mem[r_prog_len[AW-1:0]] <= LdData;
`endif
        end
    end

    // Datapath: length counter, fetch response, core reset and sticky errors
    always_ff @(posedge PHI1) begin
        if (MRST) begin
            r_prog_len <= '0;
            r_iin      <= NOP_WORD;
            r_ivalid   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_addr_err <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_ivalid <= w_fetch;
            // Released only after one full cycle spent in RUN.
            r_cpu_rst <= !((r_state == S_RUN) && (w_next == S_RUN));
            if (LdStart) begin
                r_prog_len <= '0;
                r_addr_err <= 1'b0;
                r_par_err  <= 1'b0;
            end else if (w_accept) begin
                r_prog_len <= r_prog_len + ONE_W;
            end
            if (w_fetch) begin
                r_iin <= w_hit ? w_rd_word[31:0] : NOP_WORD;
                if (!w_aligned) begin
                    r_addr_err <= 1'b1;
                end
                if (w_aligned && w_in_range && w_par_bad) begin
                    r_par_err <= 1'b1;
                end
            end
        end
    end

    assign LdReady     = w_ld_ready;
    assign IIn         = r_iin;
    assign IValid      = r_ivalid;
    assign CpuRst      = r_cpu_rst;
    assign ProgLen     = r_prog_len;
    assign AddrErr     = r_addr_err;
    assign ParErr      = r_par_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dlx_imem_ctrl.sv
// tb_dlx_imem_ctrl: directed bench for dlx_imem_ctrl.
// Fetches push their expected IIn into exp_q. A monitor on the falling
// edge pops one entry and compares it whenever IValid is high.
// Status outputs are checked directly from the main sequence.
module tb_dlx_imem_ctrl;

    localparam int AW = 5;

    logic          PHI1;
    logic          MRST;
    logic          LdStart;
    logic          LdValid;
    logic [31:0]   LdData;
    logic          LdLast;
    logic          LdReady;
    logic          IRead;
    logic [31:0]   IAddr;
    logic [31:0]   IIn;
    logic          IValid;
    logic          CpuRst;
    logic [AW:0]   ProgLen;
    logic          AddrErr;
    logic          ParErr;
    logic [1:0]    dbg_state;

    logic [31:0]   exp_q[$];
    int            total = 0;
    int            bad   = 0;

    dlx_imem_ctrl #(.MEMSIZE(26), .AW(AW), .NOP_WORD(32'h0000_0000)) dut (
        .PHI1        (PHI1),
        .MRST        (MRST),
        .LdStart     (LdStart),
        .LdValid     (LdValid),
        .LdData      (LdData),
        .LdLast      (LdLast),
        .LdReady     (LdReady),
        .IRead       (IRead),
        .IAddr       (IAddr),
        .IIn         (IIn),
        .IValid      (IValid),
        .CpuRst      (CpuRst),
        .ProgLen     (ProgLen),
        .AddrErr     (AddrErr),
        .ParErr      (ParErr),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial PHI1 = 1'b0;
    always #5 PHI1 = ~PHI1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every IValid cycle must match the oldest outstanding expectation
    always @(negedge PHI1) begin
        if (IValid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ivalid act=%h exp=none", IIn);
            end else begin
                check("fetch_iin", IIn, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge PHI1);
        #1;
    endtask

    // LdStart pulse. A junk word is offered in the same cycle; it must be dropped.
    task automatic start_load();
        LdStart = 1'b1;
        LdValid = 1'b1;
        LdData  = 32'hDEAD_BEEF;
        tick();
        LdStart = 1'b0;
        LdValid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic last);
        LdValid = 1'b1;
        LdData  = data;
        LdLast  = last;
        tick();
        LdValid = 1'b0;
        LdLast  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
        IRead = 1'b1;
        IAddr = addr;
        exp_q.push_back(exp);
        tick();
        IRead = 1'b0;
    endtask

    logic [31:0] prog4 [0:3];

    initial begin
        prog4[0] = 32'h2021_0001;
        prog4[1] = 32'h0021_1020;
        prog4[2] = 32'h0042_1821;
        prog4[3] = 32'h0800_0010;
        MRST = 1'b1; LdStart = 1'b0; LdValid = 1'b0; LdData = '0; LdLast = 1'b0;
        IRead = 1'b0; IAddr = '0;
        tick();
        tick();
        check("rst_cpurst", 32'(CpuRst), 32'd1);
        check("rst_ldready", 32'(LdReady), 32'd0);
        check("rst_iin", IIn, 32'h0);
        check("rst_ivalid", 32'(IValid), 32'd0);
        check("rst_proglen", 32'(ProgLen), 32'd0);
        check("rst_addrerr", 32'(AddrErr), 32'd0);
        check("rst_parerr", 32'(ParErr), 32'd0);
        MRST = 1'b0;
        tick();
        check("idle_ldready", 32'(LdReady), 32'd0);

        // Four-word program
        start_load();
        check("load_ldready", 32'(LdReady), 32'd1);
        for (int i = 0; i < 4; i++) push_word(prog4[i], i == 3);
        check("load4_proglen", 32'(ProgLen), 32'd4);
        check("load4_state_run", 32'(dbg_state), 32'd2);
        check("load4_cpurst_overlap", 32'(CpuRst), 32'd1);
        check("load4_ldready_off", 32'(LdReady), 32'd0);
        // IRead during the CpuRst overlap cycle is ignored (no expectation pushed)
        IRead = 1'b1; IAddr = 32'd8;
        tick();
        IRead = 1'b0;
        check("load4_cpurst_fall", 32'(CpuRst), 32'd0);
        fetch(32'd8, 32'h0042_1821);
        fetch(32'd0, 32'h2021_0001);
        fetch(32'd12, 32'h0800_0010);
        fetch(32'd16, 32'h0);
        fetch(32'd104, 32'h0);
        fetch(32'h0000_0080, 32'h0);
        tick();
        check("iin_holds", IIn, 32'h0);
        check("addrerr_clean", 32'(AddrErr), 32'd0);
        fetch(32'd6, 32'h0);
        check("addrerr_set", 32'(AddrErr), 32'd1);
        tick();
        check("addrerr_sticky", 32'(AddrErr), 32'd1);

`ifdef IMEM_PARITY_EN
        dut.r_mem[2][32] = ~dut.r_mem[2][32];
        fetch(32'd8, 32'h0);
        check("parerr_set", 32'(ParErr), 32'd1);
        fetch(32'd4, 32'h0021_1020);
`endif

        // Reload while running, LdStart and IRead together: no fetch
        LdStart = 1'b1; IRead = 1'b1; IAddr = 32'd8;
        tick();
        LdStart = 1'b0; IRead = 1'b0;
        check("reload_ivalid", 32'(IValid), 32'd0);
        check("reload_cpurst", 32'(CpuRst), 32'd1);
        check("reload_proglen", 32'(ProgLen), 32'd0);
        check("reload_addrerr", 32'(AddrErr), 32'd0);
        check("reload_parerr", 32'(ParErr), 32'd0);
        check("reload_state_load", 32'(dbg_state), 32'd1);

        // Full memory: 27 words with LdLast never set
        start_load();
        for (int i = 0; i < 27; i++) begin
            check("full_ldready", 32'(LdReady), (i < 26) ? 32'd1 : 32'd0);
            push_word(32'hA000_0000 + 32'(i), 1'b0);
        end
        check("full_proglen", 32'(ProgLen), 32'd26);
        check("full_state_run", 32'(dbg_state), 32'd2);
        tick();
        fetch(32'd100, 32'hA000_0019);
        fetch(32'd96, 32'hA000_0018);
        fetch(32'd104, 32'h0);

        // One-word program; LdValid in RUN is ignored
        start_load();
        push_word(32'h1234_5678, 1'b1);
        check("one_proglen", 32'(ProgLen), 32'd1);
        push_word(32'h5555_AAAA, 1'b0);
        check("run_ldvalid_ignored", 32'(ProgLen), 32'd1);
        fetch(32'd0, 32'h1234_5678);
        fetch(32'd4, 32'h0);

        // Reset while running
        MRST = 1'b1;
        tick();
        MRST = 1'b0;
        check("mrst_cpurst", 32'(CpuRst), 32'd1);
        check("mrst_proglen", 32'(ProgLen), 32'd0);
        check("mrst_state_idle", 32'(dbg_state), 32'd0);
        check("mrst_iin", IIn, 32'h0);

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
